// File: rtl/oven_pkg.sv
// Shared constants and types for the oven ADC front end.
// Imported by the bus interface, the BCD converter and the top.
package oven_pkg;
    localparam int ADC_W        = 12;
    localparam int TEMP_W       = 8;
    localparam int BCD_DIGITS   = 4;
    localparam int FULL_SCALE_C = 250;

    // Full-scale product width: 4095 * 250 needs 20 bits.
    localparam int PROD_W = ADC_W + $clog2(FULL_SCALE_C);

    typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/oven_adc_temp_if.sv
// Sample/result bus between the ADC readout and the oven_adc_temp block.
// The master drives samples; the slave returns temperature and BCD display code.
interface oven_adc_temp_if;
    import oven_pkg::*;

    logic [ADC_W-1:0]        data;
    logic [TEMP_W-1:0]       temp;
    logic [4*BCD_DIGITS-1:0] digit_adc;

    modport master (output data, input temp, input digit_adc);
    modport slave  (input data, output temp, output digit_adc);
endinterface

// File: rtl/oven_adc_temp_bin2bcd.sv
// Purely combinational binary-to-BCD converter (unrolled shift-add-3).
module bin2bcd
    import oven_pkg::*;
(
    input  logic [ADC_W-1:0]        bin,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SW    = ADC_W + BCD_W;

    logic [SW-1:0] scratch;
    bcd_digit_t    nib;

    // Scratch holds {bcd, bin}; each step corrects digits >= 5 then shifts in one bit.
    always_comb begin
        scratch = {{BCD_W{1'b0}}, bin};
        nib     = '0;
        for (int i = 0; i < ADC_W; i++) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                nib = scratch[ADC_W + 4*d +: 4];
                if (nib >= 4'd5) begin
                    scratch[ADC_W + 4*d +: 4] = nib + 4'd3;
                end
            end
            scratch = scratch << 1;
        end
        bcd = scratch[SW-1 -: BCD_W];
    end
endmodule

// File: rtl/oven_adc_temp.sv
// Two-stage pipeline: register ADC code, then register scaled temperature
// and its BCD display copy, both derived from the same captured sample.
module oven_adc_temp
    import oven_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    oven_adc_temp_if.slave   bus
);
    logic [ADC_W-1:0]        data_q,  data_d;
    logic [TEMP_W-1:0]       temp_q,  temp_d;
    logic [4*BCD_DIGITS-1:0] digit_q, digit_d;
    logic [PROD_W-1:0]       product;
    logic [4*BCD_DIGITS-1:0] bcd_w;

    bin2bcd u_bin2bcd (
        .bin (data_q),
        .bcd (bcd_w)
    );

    // Result never exceeds 249, so truncating the shifted product is lossless.
    always_comb begin
        data_d  = bus.data;
        product = PROD_W'(data_q) * PROD_W'(FULL_SCALE_C);
        temp_d  = TEMP_W'(product >> ADC_W);
        digit_d = bcd_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            temp_q  <= '0;
            digit_q <= '0;
        end else begin
            data_q  <= data_d;
            temp_q  <= temp_d;
            digit_q <= digit_d;
        end
    end

    assign bus.temp      = temp_q;
    assign bus.digit_adc = digit_q;
endmodule

// File: tb/tb_oven_adc_temp.sv
// Directed bench for oven_adc_temp: reset, nominal, step, extremes,
// full-range streaming and mid-stream reset.
module tb_oven_adc_temp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    oven_adc_temp_if bus();

    oven_adc_temp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.data = 12'd1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.temp !== 8'd0 || bus.digit_adc !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d temp=%0d bcd=%h required 0/0000", i, bus.temp, bus.digit_adc);
            end else
                $display("reset_hold cyc=%0d temp=%0d bcd=%h", i, bus.temp, bus.digit_adc);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.temp !== 8'd0 || bus.digit_adc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rel1 temp=%0d bcd=%h required 0/0000", bus.temp, bus.digit_adc);
        end else
            $display("reset_rel1 temp=%0d bcd=%h", bus.temp, bus.digit_adc);
        tick();
        // 1234*250 = 308500; 308500/4096 = 75.3 -> 75
        checks++;
        if (bus.temp !== 8'd75 || bus.digit_adc !== 16'h1234) begin
            errors++;
            $display("FAIL reset_rel2 temp=%0d bcd=%h required 75/1234", bus.temp, bus.digit_adc);
        end else
            $display("reset_rel2 temp=%0d bcd=%h", bus.temp, bus.digit_adc);
    endtask

    task automatic test_nominal();
        bus.data = 12'd2500;
        tick();
        tick();
        checks++;
        if (bus.temp !== 8'd152 || bus.digit_adc !== 16'h2500) begin
            errors++;
            $display("FAIL nominal temp=%0d bcd=%h required 152/2500", bus.temp, bus.digit_adc);
        end else
            $display("nominal data=2500 temp=%0d bcd=%h", bus.temp, bus.digit_adc);
    endtask

    task automatic test_step();
        bus.data = 12'd2500;
        tick();
        bus.data = 12'd500;
        tick();
        checks++;
        if (bus.temp !== 8'd152 || bus.digit_adc !== 16'h2500) begin
            errors++;
            $display("FAIL step_a temp=%0d bcd=%h required 152/2500", bus.temp, bus.digit_adc);
        end else
            $display("step_a temp=%0d bcd=%h", bus.temp, bus.digit_adc);
        tick();
        checks++;
        if (bus.temp !== 8'd30 || bus.digit_adc !== 16'h0500) begin
            errors++;
            $display("FAIL step_b temp=%0d bcd=%h required 30/0500", bus.temp, bus.digit_adc);
        end else
            $display("step_b temp=%0d bcd=%h", bus.temp, bus.digit_adc);
    endtask

    task automatic test_extremes();
        logic [11:0] vin  [3] = '{12'd0, 12'd4095, 12'd999};
        logic [7:0]  vtmp [3] = '{8'd0, 8'd249, 8'd60};
        logic [15:0] vbcd [3] = '{16'h0000, 16'h4095, 16'h0999};
        for (int k = 0; k < 3; k++) begin
            bus.data = vin[k];
            tick();
            tick();
            checks++;
            if (bus.temp !== vtmp[k] || bus.digit_adc !== vbcd[k]) begin
                errors++;
                $display("FAIL extreme data=%0d temp=%0d bcd=%h required %0d/%h", vin[k], bus.temp, bus.digit_adc, vtmp[k], vbcd[k]);
            end else
                $display("extreme data=%0d temp=%0d bcd=%h", vin[k], bus.temp, bus.digit_adc);
        end
    endtask

    task automatic test_streaming();
        int          prev;
        int          exp_t;
        logic [15:0] exp_b;
        logic        nib_bad;
        int          stream_err = 0;
        for (int i = 0; i <= 4096; i++) begin
            bus.data = 12'(i % 4096);
            tick();
            if (i >= 1) begin
                prev  = i - 1;
                exp_t = (prev * 250) / 4096;
                exp_b = {4'(prev / 1000), 4'((prev / 100) % 10), 4'((prev / 10) % 10), 4'(prev % 10)};
                nib_bad = 1'b0;
                for (int d = 0; d < 4; d++)
                    if (bus.digit_adc[4*d +: 4] > 4'd9) nib_bad = 1'b1;
                checks++;
                if (bus.temp !== 8'(exp_t) || bus.digit_adc !== exp_b || nib_bad) begin
                    errors++;
                    stream_err++;
                    $display("FAIL stream data=%0d temp=%0d bcd=%h required %0d/%h", prev, bus.temp, bus.digit_adc, exp_t, exp_b);
                end
            end
        end
        $display("stream codes=0..4095 errors=%0d", stream_err);
    endtask

    task automatic test_midstream_reset();
        bus.data = 12'd100;
        tick();
        bus.data = 12'd200;
        tick();
        bus.data = 12'd300;
        rst_n    = 1'b0;
        tick();
        checks++;
        if (bus.temp !== 8'd0 || bus.digit_adc !== 16'h0000) begin
            errors++;
            $display("FAIL mid_rst_edge temp=%0d bcd=%h required 0/0000", bus.temp, bus.digit_adc);
        end else
            $display("mid_rst_edge temp=%0d bcd=%h", bus.temp, bus.digit_adc);
        rst_n    = 1'b1;
        bus.data = 12'd400;
        tick();
        checks++;
        if (bus.temp !== 8'd0 || bus.digit_adc !== 16'h0000) begin
            errors++;
            $display("FAIL mid_rst_rel1 temp=%0d bcd=%h required 0/0000", bus.temp, bus.digit_adc);
        end else
            $display("mid_rst_rel1 temp=%0d bcd=%h", bus.temp, bus.digit_adc);
        bus.data = 12'd500;
        tick();
        // 400*250 = 100000; 100000/4096 = 24.4 -> 24
        checks++;
        if (bus.temp !== 8'd24 || bus.digit_adc !== 16'h0400) begin
            errors++;
            $display("FAIL mid_rst_rel2 temp=%0d bcd=%h required 24/0400", bus.temp, bus.digit_adc);
        end else
            $display("mid_rst_rel2 temp=%0d bcd=%h", bus.temp, bus.digit_adc);
    endtask

    initial begin
        bus.data = '0;
        test_reset();
        test_nominal();
        test_step();
        test_extremes();
        test_streaming();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
